// File: rtl/multirate_pkg.sv
// Shared widths, FSM state type and the output rounding/saturation helper
// for the multirate filterbank sequencer.
package multirate_pkg;

  localparam int DATA_W = 16;
  localparam int COEF_W = 13;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + 4;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (DATA_W - 1)) - 64'sd1;
  localparam logic signed [63:0] SAT_MIN = -(64'sd1 <<< (DATA_W - 1));

  // Round half up, arithmetic shift, then clamp to the signed output range.
  function automatic logic signed [DATA_W-1:0] sat_round(
    input logic signed [63:0] acc,
    input int                 shift
  );
    logic signed [63:0] r;
    r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    if (r > SAT_MAX) r = SAT_MAX;
    else if (r < SAT_MIN) r = SAT_MIN;
    return DATA_W'(r);
  endfunction

endpackage

// File: rtl/mac_mul_16s_13ns.sv
// Combinational signed sample times unsigned coefficient multiplier.
// The coefficient is zero-extended so its top bit is magnitude, never sign.
module mac_mul_16s_13ns
  import multirate_pkg::*;
(
  input  logic signed [DATA_W-1:0] a,
  input  logic        [COEF_W-1:0] b,
  output logic signed [PROD_W-1:0] p
);

  logic signed [PROD_W-1:0] a_x;
  logic signed [PROD_W-1:0] b_x;

  assign a_x = PROD_W'(a);
  assign b_x = PROD_W'($signed({1'b0, b}));
  assign p   = a_x * b_x;

endmodule

// File: rtl/multirate_mac_sequencer.sv
// Time-multiplexed polyphase FIR decimator: collects DECIM samples, then runs
// one NUM_TAPS-cycle MAC pass through a shared multiplier and emits one result.
module multirate_mac_sequencer
  import multirate_pkg::*;
#(
  parameter int NUM_TAPS  = 16,
  parameter int DECIM     = 2,
  parameter int OUT_SHIFT = 12
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic signed [DATA_W-1:0]    s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [$clog2(NUM_TAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]           coef_data,
  output logic signed [DATA_W-1:0]    m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        busy,
  output state_t                      state
);

  localparam int KW    = $clog2(NUM_TAPS);
  localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int ACC_L = PROD_W + KW;
  localparam logic [KW-1:0]   K_LAST  = KW'(NUM_TAPS - 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

  // Stream handshakes: a transfer happens on a rising edge where valid and
  // ready are both high; m_data/m_valid are held until that edge.

  logic signed [DATA_W-1:0] dl [NUM_TAPS];
  logic [PH_W-1:0]          phase;
  logic [KW-1:0]            k;
  logic signed [ACC_L-1:0]  acc;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_L-1:0]  prod_x;
  logic signed [ACC_L-1:0]  acc_f;

  mac_mul_16s_13ns u_mul (
    .a (dl[k]),
    .b (coef_data),
    .p (prod)
  );

  assign prod_x    = ACC_L'(prod);
  assign acc_f     = acc + prod_x;
  assign s_ready   = (state == IDLE) && !ap_rst;
  assign busy      = (state == MAC) || (state == OUT);
  assign coef_addr = k;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state   <= IDLE;
      phase   <= '0;
      k       <= '0;
      acc     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      for (int i = 0; i < NUM_TAPS; i++) dl[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_valid) begin
            dl[0] <= s_data;
            for (int i = 1; i < NUM_TAPS; i++) dl[i] <= dl[i-1];
            if (phase == PH_LAST) begin
              phase <= '0;
              k     <= '0;
              state <= MAC;
            end else begin
              phase <= phase + 1'b1;
            end
          end
        end
        MAC: begin
          // Tap 0 overwrites the accumulator, so no clearing cycle is needed.
          acc <= (k == '0) ? prod_x : acc_f;
          k   <= k + 1'b1;
          if (k == K_LAST) begin
            m_data  <= sat_round(64'(acc_f), OUT_SHIFT);
            m_valid <= 1'b1;
            state   <= OUT;
          end
        end
        OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multirate_mac_sequencer.sv
// Bench for the FIR decimator: a sample-history model predicts every output,
// a per-cycle compare process checks the stream, literals pin the model.
module tb_multirate_mac_sequencer;
  import multirate_pkg::*;

  logic               ap_clk = 1'b0;
  logic               ap_rst;
  logic signed [15:0] s_data;
  logic               s_valid;
  logic               s_ready;
  logic [3:0]         coef_addr;
  logic [12:0]        coef_data;
  logic signed [15:0] m_data;
  logic               m_valid;
  logic               m_ready;
  logic               busy;
  state_t             st;

  logic signed [15:0] r_s_data;
  logic               r_s_valid;
  logic               r_s_ready;
  logic [3:0]         r_coef_addr;
  logic [12:0]        r_coef_data;
  logic signed [15:0] r_m_data;
  logic               r_m_valid;
  logic               r_m_ready;
  logic               r_busy;
  state_t             r_st;

  logic [12:0] rom [16];
  assign coef_data   = rom[coef_addr];
  assign r_coef_data = (r_coef_addr == 4'd0) ? 13'd1 : 13'd0;

  multirate_mac_sequencer dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .coef_addr(coef_addr), .coef_data(coef_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .state(st)
  );

  multirate_mac_sequencer #(.DECIM(1)) u_d1 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .s_data(r_s_data), .s_valid(r_s_valid),
    .s_ready(r_s_ready), .coef_addr(r_coef_addr), .coef_data(r_coef_data),
    .m_data(r_m_data), .m_valid(r_m_valid), .m_ready(r_m_ready), .busy(r_busy), .state(r_st)
  );

  // clock / reset block
  always #5 ap_clk = ~ap_clk;
  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  // behavioural model: newest sample first, one output per DECIM samples
  longint     hist [16];
  int         nacc;
  logic [15:0] exp_q [$];
  logic [15:0] got_q [$];

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) hist[i] = 0;
    nacc = 0;
    exp_q.delete();
  endfunction

  function automatic void model_accept(input longint x);
    longint sum, r;
    for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
    nacc++;
    if (nacc == 2) begin
      nacc = 0;
      sum  = 0;
      for (int i = 0; i < 16; i++) sum += hist[i] * longint'(rom[i]);
      r = (sum + 2048) >>> 12;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      exp_q.push_back(16'(r));
    end
  endfunction

  // scoreboard / compare process
  bit          held = 0, hs_last = 0, measure = 0, have_prev = 0;
  logic [15:0] held_val;
  int          prev_hs, sr_cnt, busy_cnt;

  always @(negedge ap_clk) begin
    #2;
    if (ap_rst) begin
      check("rst_m_valid", m_valid, 0);
      check("rst_s_ready", s_ready, 0);
      held = 0;
      hs_last = 0;
    end else begin
      if (hs_last) check("s_ready_after_out", s_ready, 1);
      if (measure) begin
        sr_cnt   += int'(s_ready);
        busy_cnt += int'(busy);
      end
      if (m_valid) begin
        check("out_s_ready", s_ready, 0);
        if (held) check("hold_data", longint'(m_data), longint'($signed(held_val)));
        if (m_ready) begin
          if (exp_q.size() == 0) check("unexpected_out", 1, 0);
          else check("m_data", longint'(m_data), longint'($signed(exp_q.pop_front())));
          got_q.push_back(m_data);
          if (measure) begin
            if (have_prev) begin
              check("out_spacing", cyc - prev_hs, 19);
              check("s_ready_cycles", sr_cnt, 2);
              check("busy_cycles", busy_cnt, 17);
            end
            have_prev = 1;
            prev_hs   = cyc;
            sr_cnt    = 0;
            busy_cnt  = 0;
          end
          held = 0;
          hs_last = 1;
        end else begin
          held = 1;
          held_val = m_data;
          hs_last = 0;
        end
      end else begin
        held = 0;
        hs_last = 0;
      end
    end
  end

  // driver tasks (called at a falling edge)
  int acc_c;

  task automatic send(input logic signed [15:0] x);
    bit ok = 0;
    bit rdy;
    s_data  = x;
    s_valid = 1'b1;
    for (int t = 0; t < 300 && !ok; t++) begin
      #1;
      rdy = s_ready;
      acc_c = cyc;
      @(posedge ap_clk);
      if (rdy) begin
        ok = 1;
        model_accept(longint'(x));
      end
      @(negedge ap_clk);
    end
    s_valid = 1'b0;
    check("send_timeout", ok, 1);
  endtask

  task automatic wait_mvalid();
    bit seen = 0;
    for (int t = 0; t < 300 && !seen; t++) begin
      @(negedge ap_clk);
      #1;
      seen = m_valid;
    end
    check("m_valid_timeout", seen, 1);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int t = 0; t < 1000 && !done; t++) begin
      @(negedge ap_clk);
      #1;
      done = (exp_q.size() == 0) && !m_valid && !busy;
    end
    check("drain_timeout", done, 1);
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    ap_rst  = 1'b1;
    s_valid = 1'b0;
    model_clear();
    repeat (3) @(negedge ap_clk);
    ap_rst = 1'b0;
    #1;
    check("post_rst_s_ready", s_ready, 1);
    check("post_rst_m_valid", m_valid, 0);
    check("post_rst_m_data", longint'(m_data), 0);
    check("post_rst_coef_addr", coef_addr, 0);
    check("post_rst_busy", busy, 0);
  endtask

  task automatic impulse();
    for (int i = 0; i < 16; i++) rom[i] = 13'(i + 1);
    got_q.delete();
    m_ready = 1'b1;
    send(16'sd4096);
    send(16'sd0);
    wait_mvalid();
    check("latency", cyc - acc_c, 17);
    send(16'sd0);
    send(16'sd0);
    wait_idle();
    check("impulse_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("impulse_out0", longint'($signed(got_q[0])), 2);
      check("impulse_out1", longint'($signed(got_q[1])), 4);
    end
  endtask

  task automatic round_case(input logic signed [15:0] x, input logic signed [15:0] e);
    bit ok = 0;
    bit got_it = 0;
    bit rdy;
    @(negedge ap_clk);
    r_s_data  = x;
    r_s_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      #1;
      rdy = r_s_ready;
      @(posedge ap_clk);
      ok = rdy;
      @(negedge ap_clk);
    end
    r_s_valid = 1'b0;
    check("round_send_timeout", ok, 1);
    for (int t = 0; t < 60 && !got_it; t++) begin
      #1;
      if (r_m_valid) begin
        got_it = 1;
        check("round", longint'(r_m_data), longint'(e));
      end else begin
        @(negedge ap_clk);
      end
    end
    check("round_timeout", got_it, 1);
  endtask

  initial begin
    ap_rst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    m_ready = 1'b1;
    r_s_valid = 1'b0;
    r_s_data = '0;
    r_m_ready = 1'b1;
    for (int i = 0; i < 16; i++) rom[i] = 13'(i + 1);
    model_clear();
    do_reset();

    // rounding on the DECIM=1 instance
    round_case(16'sd2048, 16'sd1);
    round_case(16'sd2047, 16'sd0);
    round_case(-16'sd2048, 16'sd0);
    round_case(-16'sd2049, -16'sd1);

    impulse();

    // saturation
    for (int i = 0; i < 16; i++) rom[i] = 13'd8191;
    got_q.delete();
    for (int i = 0; i < 16; i++) send(16'sd32767);
    for (int i = 0; i < 16; i++) send(-16'sd32768);
    wait_idle();
    check("sat_count", got_q.size(), 16);
    if (got_q.size() == 16) begin
      check("sat_pos", longint'($signed(got_q[7])), 32767);
      check("sat_neg", longint'($signed(got_q[15])), -32768);
    end

    // backpressure: sample offered during OUT must wait
    for (int i = 0; i < 16; i++) rom[i] = 13'($urandom_range(0, 8191));
    m_ready = 1'b0;
    send(16'sd1000);
    send(-16'sd3000);
    wait_mvalid();
    fork
      begin
        repeat (10) @(negedge ap_clk);
        m_ready = 1'b1;
      end
      begin
        send(16'sd123);
        send(16'sd456);
      end
    join
    wait_idle();

    // reset in the middle of a MAC pass
    for (int i = 0; i < 16; i++) rom[i] = 13'(i + 1);
    send(16'sd4096);
    send(16'sd0);
    begin
      bit hit = 0;
      for (int t = 0; t < 100 && !hit; t++) begin
        @(negedge ap_clk);
        #1;
        hit = busy && (coef_addr == 4'd5);
      end
      check("reach_k5", hit, 1);
    end
    do_reset();
    impulse();

    // throughput with continuous traffic
    m_ready   = 1'b1;
    have_prev = 0;
    sr_cnt    = 0;
    busy_cnt  = 0;
    measure   = 1;
    for (int i = 0; i < 12; i++) send(16'($urandom_range(0, 65535)));
    measure = 0;
    wait_idle();

    // randomized traffic with random backpressure
    for (int i = 0; i < 16; i++) rom[i] = 13'($urandom_range(0, 8191));
    begin
      bit done = 0;
      fork
        begin
          for (int i = 0; i < 40; i++) send(16'($urandom_range(0, 65535)));
          done = 1;
        end
        begin
          while (!done) begin
            @(negedge ap_clk);
            m_ready = 1'($urandom_range(0, 1));
          end
        end
      join
    end
    m_ready = 1'b1;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
